// File: rtl/sha256_padder.sv
// sha256_padder: FIPS 180-4 message padder feeding 16-word blocks to a SHA-256 schedule,
// then holding inner_busy for ROUNDS cycles per block.
module sha256_padder #(
  parameter int ROUNDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] msg_data,
  input  logic        msg_valid,
  input  logic        msg_last,
  input  logic [2:0]  msg_bytes,
  output logic        msg_ready,
  input  logic        msg_empty,
  output logic [31:0] data,
  output logic        write_enable,
  output logic        inner_busy,
  output logic        first_block,
  output logic        msg_done
);
  localparam int RW = $clog2(ROUNDS + 1);
  typedef enum logic [2:0] {IDLE, LOAD, PAD, RUN, DONE} state_t;
  state_t      state_q;
  logic [4:0]  w_q, w_d;
  logic [60:0] cnt_q, cnt_d;
  logic [RW-1:0] rcnt_q;
  logic        mark_q, carry_q, fin_q, len_done_q;
  logic [31:0] data_q, word_d, pad_d;
  logic        we_q, busy_q, first_q, done_q;
  logic        hs;
  logic [2:0]  nb;
  logic [63:0] len;
  assign msg_ready    = reset && (state_q == IDLE || (state_q == LOAD && w_q < 5'd16));
  assign hs           = msg_valid && msg_ready;
  assign nb           = (msg_bytes == 3'd0 || msg_bytes > 3'd4) ? 3'd4 : msg_bytes;
  assign w_d          = w_q + 5'd1;
  assign cnt_d        = cnt_q + 61'(msg_last ? nb : 3'd4);
  assign len          = {cnt_q, 3'b000};
  // a short final word carries the marker in its first unused byte
  assign word_d       = !msg_last  ? msg_data :
                        nb == 3'd1 ? {msg_data[31:24], 24'h800000} :
                        nb == 3'd2 ? {msg_data[31:16], 16'h8000} :
                        nb == 3'd3 ? {msg_data[31:8], 8'h80} : msg_data;
  // carry_q: the length no longer fits in this block, so fill it with zeros
  assign pad_d        = mark_q                         ? 32'h80000000 :
                        (carry_q || w_q < 5'd14)        ? 32'h0 :
                        w_q == 5'd14                    ? len[63:32] : len[31:0];
  assign data         = data_q;
  assign write_enable = we_q;
  assign inner_busy   = busy_q;
  assign first_block  = first_q;
  assign msg_done     = done_q;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      w_q        <= '0;
      cnt_q      <= '0;
      rcnt_q     <= '0;
      mark_q     <= 1'b0;
      carry_q    <= 1'b0;
      fin_q      <= 1'b0;
      len_done_q <= 1'b0;
      data_q     <= '0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      first_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE, LOAD: begin
          if (hs) begin
            data_q  <= word_d;
            we_q    <= 1'b1;
            w_q     <= w_d;
            cnt_q   <= cnt_d;
            first_q <= first_q || state_q == IDLE;
            if (msg_last) begin
              fin_q   <= 1'b1;
              mark_q  <= nb == 3'd4;
              carry_q <= nb != 3'd4 && w_q >= 5'd14;
            end
            state_q <= w_d == 5'd16 ? RUN : msg_last ? PAD : LOAD;
          end else if (state_q == IDLE && msg_empty) begin
            mark_q  <= 1'b1;
            fin_q   <= 1'b1;
            first_q <= 1'b1;
            state_q <= PAD;
          end
        end
        PAD: begin
          data_q <= pad_d;
          we_q   <= 1'b1;
          w_q    <= w_d;
          mark_q <= 1'b0;
          if (mark_q && w_q >= 5'd14) carry_q <= 1'b1;
          if (!mark_q && !carry_q && w_q == 5'd15) len_done_q <= 1'b1;
          if (w_d == 5'd16) state_q <= RUN;
        end
        RUN: begin
          if (rcnt_q == RW'(ROUNDS)) begin
            busy_q  <= 1'b0;
            rcnt_q  <= '0;
            w_q     <= '0;
            carry_q <= 1'b0;
            first_q <= 1'b0;
            done_q  <= len_done_q;
            state_q <= len_done_q ? DONE : fin_q ? PAD : LOAD;
          end else begin
            busy_q <= 1'b1;
            rcnt_q <= rcnt_q + 1'b1;
          end
        end
        DONE: begin
          cnt_q      <= '0;
          fin_q      <= 1'b0;
          len_done_q <= 1'b0;
          mark_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_padder.sv
// tb_sha256_padder: directed checks of padding, block timing, flags and reset of sha256_padder.
module tb_sha256_padder;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] msg_data = '0;
  logic        msg_valid = 1'b0, msg_last = 1'b0, msg_empty = 1'b0;
  logic [2:0]  msg_bytes = '0;
  logic        msg_ready;
  logic [31:0] data;
  logic        write_enable, inner_busy, first_block, msg_done;
  int checks = 0, failures = 0;
  logic [7:0]  m[$];
  logic [31:0] exp_q[$], got_q[$];
  bit          mon_en = 0;
  int busy_cnt, done_cnt, overlap, first_we, first_busy, ready_busy;

  sha256_padder #(.ROUNDS(64)) dut (
    .clk(clk), .reset(reset), .msg_data(msg_data), .msg_valid(msg_valid),
    .msg_last(msg_last), .msg_bytes(msg_bytes), .msg_ready(msg_ready),
    .msg_empty(msg_empty), .data(data), .write_enable(write_enable),
    .inner_busy(inner_busy), .first_block(first_block), .msg_done(msg_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mon_en) begin
    if (write_enable) begin got_q.push_back(data); if (first_block) first_we++; end
    if (inner_busy) begin busy_cnt++; if (first_block) first_busy++; if (msg_ready) ready_busy++; end
    if (write_enable && inner_busy) overlap++;
    if (msg_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference padding: bytes, 0x80, zeros to 56 mod 64, 64-bit big-endian bit length
  function automatic void build_exp();
    logic [7:0] b[$];
    logic [63:0] bits;
    b = m;
    bits = 64'(m.size()) * 64'd8;
    b.push_back(8'h80);
    while (b.size() % 64 != 56) b.push_back(8'h00);
    for (int i = 7; i >= 0; i--) b.push_back(8'(bits >> (8 * i)));
    exp_q.delete();
    for (int i = 0; i < b.size(); i += 4) exp_q.push_back({b[i], b[i+1], b[i+2], b[i+3]});
  endfunction

  function automatic void fill(input int n, input int seed);
    m.delete();
    for (int i = 0; i < n; i++) m.push_back(8'(i * 37 + seed));
  endfunction

  task automatic send(input bit gap, input int stop);
    int n, nw, t;
    logic [31:0] w;
    n = m.size();
    nw = (n + 3) / 4;
    for (int i = 0; i < nw && i < stop; i++) begin
      w = '0;
      for (int k = 0; k < 4; k++) w = {w[23:0], (4 * i + k < n) ? m[4 * i + k] : 8'hEE};
      @(negedge clk);
      if (gap && i > 0) begin msg_valid = 1'b0; @(negedge clk); end
      msg_valid = 1'b1;
      msg_data  = w;
      msg_last  = (i == nw - 1);
      msg_bytes = (i == nw - 1) ? 3'(n - 4 * i) : 3'd2;
      t = 0;
      while (!msg_ready && t < 500) begin @(negedge clk); t++; end
      if (t >= 500) begin chk("ready_timeout", 0, 1); break; end
      @(posedge clk);
    end
    @(negedge clk);
    msg_valid = 1'b0;
    msg_last  = 1'b0;
  endtask

  task automatic start_mon();
    got_q.delete();
    busy_cnt = 0; done_cnt = 0; overlap = 0; first_we = 0; first_busy = 0; ready_busy = 0;
    mon_en = 1;
  endtask

  task automatic run_msg(input string tag, input bit gap);
    int t;
    build_exp();
    start_mon();
    if (m.size() == 0) begin
      @(negedge clk); msg_empty = 1'b1;
      @(negedge clk); msg_empty = 1'b0;
    end else send(gap, 1000);
    t = 0;
    while (done_cnt == 0 && t < 1000) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    mon_en = 0;
    chk({tag, "_nwords"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    chk({tag, "_busy"}, 64'(busy_cnt), 64'(64 * (exp_q.size() / 16)));
    chk({tag, "_done"}, 64'(done_cnt), 64'd1);
    chk({tag, "_overlap"}, 64'(overlap), 64'd0);
    chk({tag, "_first_we"}, 64'(first_we), 64'd16);
    chk({tag, "_first_busy"}, 64'(first_busy), 64'd64);
    chk({tag, "_ready_busy"}, 64'(ready_busy), 64'd0);
  endtask

  initial begin
    int t;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(msg_ready), 0);
    chk("rst_outs", 64'({data, write_enable, inner_busy, first_block, msg_done}), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_ready", 64'(msg_ready), 1);
    chk("idle_outs", 64'({data, write_enable, inner_busy, first_block, msg_done}), 0);

    m.delete();
    run_msg("empty", 0);
    chk("empty_w0", 64'(got_q.size() > 0 ? got_q[0] : 32'h0), 64'h80000000);

    m = '{8'h61, 8'h62, 8'h63};
    run_msg("abc", 0);
    chk("abc_w0", 64'(got_q.size() > 0 ? got_q[0] : 32'h0), 64'h61626380);
    chk("abc_w15", 64'(got_q.size() > 15 ? got_q[15] : 32'h0), 64'h18);

    fill(56, 3);  run_msg("w14", 0);
    chk("w14_len", 64'(got_q.size() > 31 ? got_q[31] : 32'h0), 64'h1C0);
    fill(65, 9);  run_msg("w16p1", 0);
    chk("w16p1_len", 64'(got_q.size() > 31 ? got_q[31] : 32'h0), 64'h208);
    fill(17, 5);  run_msg("gap5", 1);
    fill(17, 5);  run_msg("b2b5", 0);
    fill(59, 11); run_msg("w15s", 0);
    fill(60, 13); run_msg("w15f", 0);

    fill(100, 1);
    start_mon();
    send(0, 16);
    t = 0;
    while (busy_cnt < 30 && t < 500) begin @(negedge clk); t++; end
    chk("mid_busy", 64'(inner_busy), 1);
    mon_en = 0;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_outs", 64'({msg_ready, data, write_enable, inner_busy, first_block, msg_done}), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_idle_ready", 64'(msg_ready), 1);
    m = '{8'h61, 8'h62, 8'h63};
    run_msg("abc2", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
